// File: rtl/i2s_sample_rx_pkg.sv
// Shared audio definitions for the I2S receive path: framer states and
// the standard slot length of the 32 x fs board link.
package i2s_sample_rx_pkg;

    typedef enum logic [1:0] {
        SYNC     = 2'd0,
        RX_LEFT  = 2'd1,
        RX_RIGHT = 2'd2
    } i2s_state_t;

    localparam int I2S_SLOT_BITS_32FS = 16;

    // Bit counter width; the counter saturates at its all-ones value.
    localparam int         CNT_W   = 6;
    localparam logic [5:0] CNT_MAX = 6'd63;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings the three asynchronous I2S lines into the CLK domain and flags
// each BCLK rising edge, with LRCLK/DIN aligned to that rise.
module i2s_sync_edge (
    input  logic CLK,
    input  logic RESET_n,
    input  logic BCLK,
    input  logic LRCLK,
    input  logic DIN,
    output logic RISE,
    output logic LR,
    output logic DIN_S
);

    logic [2:0] bclk_q;
    logic [1:0] lr_q;
    logic [1:0] din_q;

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            bclk_q <= '0;
            lr_q   <= '0;
            din_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], BCLK};
            lr_q   <= {lr_q[0], LRCLK};
            din_q  <= {din_q[0], DIN};
        end
    end

    // All three lines see the same two-stage delay, so LR/DIN_S hold the
    // values present at the pins when BCLK rose.
    assign RISE  = bclk_q[1] & ~bclk_q[2];
    assign LR    = lr_q[1];
    assign DIN_S = din_q[1];

endmodule

// File: rtl/i2s_sample_rx.sv
// Philips I2S receiver: oversamples BCLK/LRCLK/DIN in the CLK domain,
// rebuilds stereo frames and holds each one on a VALID/READY port.
module i2s_sample_rx
    import i2s_sample_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = I2S_SLOT_BITS_32FS,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic                  I2S_BCLK,
    input  logic                  I2S_LRCLK,
    input  logic                  I2S_DIN,
    output logic [DATA_WIDTH-1:0] LEFT,
    output logic [DATA_WIDTH-1:0] RIGHT,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  OVERRUN,
    output logic                  FRAME_ERR,
    output logic                  LOCKED,
    input  logic                  CLEAR,
    output i2s_state_t            STATE
);

    localparam int             TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [6:0]     SLOT7  = 7'(SLOT_BITS);
    localparam logic [6:0]     DW7    = 7'(DATA_WIDTH);

    logic                  rise;
    logic                  lr;
    logic                  din;
    logic                  lr_prev;
    i2s_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_sat;
    logic [6:0]            cnt_inc;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] sh_next;
    logic [DATA_WIDTH-1:0] pend_left;
    logic [DATA_WIDTH-1:0] done_left;
    logic [DATA_WIDTH-1:0] done_right;
    logic                  done;
    logic                  slot_end;
    logic [TO_W-1:0]       tcnt;

    i2s_sync_edge u_sync (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .BCLK    (I2S_BCLK),
        .LRCLK   (I2S_LRCLK),
        .DIN     (I2S_DIN),
        .RISE    (rise),
        .LR      (lr),
        .DIN_S   (din)
    );

    always_comb begin
        cnt_inc  = {1'b0, cnt} + 7'd1;
        cnt_sat  = (cnt == CNT_MAX) ? cnt : cnt + 6'd1;
        slot_end = (state == RX_LEFT) ? lr : ~lr;
        sh_next  = sh;
        if ({1'b0, cnt} < DW7) begin
            sh_next = {sh[DATA_WIDTH-2:0], din};
        end
    end

    // Framer. In Philips framing the rise that shows the new LRCLK level
    // still carries the last bit of the slot being closed.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state      <= SYNC;
            lr_prev    <= 1'b0;
            cnt        <= '0;
            sh         <= '0;
            pend_left  <= '0;
            done_left  <= '0;
            done_right <= '0;
            done       <= 1'b0;
            FRAME_ERR  <= 1'b0;
            tcnt       <= '0;
        end else begin
            done      <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (rise) begin
                tcnt    <= '0;
                lr_prev <= lr;
                case (state)
                    SYNC: begin
                        if (lr_prev && !lr) begin
                            sh    <= '0;
                            cnt   <= '0;
                            state <= RX_LEFT;
                        end
                    end
                    RX_LEFT, RX_RIGHT: begin
                        sh  <= sh_next;
                        cnt <= cnt_sat;
                        if (slot_end) begin
                            if (cnt_inc == SLOT7) begin
                                cnt <= '0;
                                sh  <= '0;
                                if (state == RX_LEFT) begin
                                    pend_left <= sh_next;
                                    state     <= RX_RIGHT;
                                end else begin
                                    done_left  <= pend_left;
                                    done_right <= sh_next;
                                    done       <= 1'b1;
                                    state      <= RX_LEFT;
                                end
                            end else begin
                                FRAME_ERR <= 1'b1;
                                state     <= SYNC;
                            end
                        end else if (cnt_inc > SLOT7) begin
                            FRAME_ERR <= 1'b1;
                            state     <= SYNC;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end else if (tcnt != TO_MAX) begin
                tcnt <= tcnt + TO_W'(1);
            end else begin
                // Link lost: drop any partial frame silently.
                state <= SYNC;
                cnt   <= '0;
            end
        end
    end

    // Output holding register and handshake.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            LEFT    <= '0;
            RIGHT   <= '0;
            VALID   <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (done) begin
                LEFT  <= done_left;
                RIGHT <= done_right;
                VALID <= 1'b1;
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end
            if (done && VALID && !READY) begin
                OVERRUN <= 1'b1;
            end else if (CLEAR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

    assign LOCKED = (state == RX_LEFT) || (state == RX_RIGHT);
    assign STATE  = state;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Bench for i2s_sample_rx: drives a Philips I2S transmitter on an
// asynchronous BCLK and checks delivered frames against a frame queue.
`timescale 1ns/1ps
module tb_i2s_sample_rx;
    import i2s_sample_rx_pkg::*;

    localparam int DW = 16;
    localparam int SB = 16;
    localparam int TO = 1023;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bclk  = 1'b0;
    logic lrclk = 1'b0;
    logic din   = 1'b0;
    logic ready = 1'b1;
    logic clear = 1'b0;
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    logic valid, overrun, frame_err, locked;
    i2s_state_t state;

    always #5 clk = ~clk;

    i2s_sample_rx #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .TIMEOUT(TO)) dut (
        .CLK       (clk),
        .RESET_n   (rst_n),
        .I2S_BCLK  (bclk),
        .I2S_LRCLK (lrclk),
        .I2S_DIN   (din),
        .LEFT      (left),
        .RIGHT     (right),
        .VALID     (valid),
        .READY     (ready),
        .OVERRUN   (overrun),
        .FRAME_ERR (frame_err),
        .LOCKED    (locked),
        .CLEAR     (clear),
        .STATE     (state)
    );

    int errors   = 0;
    int checks   = 0;
    int loads    = 0;
    int ferr_cnt = 0;
    logic [2*DW-1:0] exp_q[$];
    logic bit_prev   = 1'b0;
    logic rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    logic p_valid = 1'b0, p_ready = 1'b0, p_clear = 1'b0, p_rstn = 1'b0, p_ferr = 1'b0;
    logic ovr_exp = 1'b0;
    logic [DW-1:0] p_left = '0, p_right = '0;

    always @(negedge clk) begin
        logic load;
        logic [2*DW-1:0] f;
        if (!p_rstn) begin
            chk("reset_valid", valid, 0);
            chk("reset_left", left, 0);
            chk("reset_right", right, 0);
            chk("reset_overrun", overrun, 0);
            chk("reset_ferr", frame_err, 0);
            chk("reset_locked", locked, 0);
            chk("reset_state", state, SYNC);
            ovr_exp = 1'b0;
        end else begin
            // A new frame shows as VALID rising, VALID staying up after an
            // accept, or the held words changing.
            load = valid && (!p_valid || p_ready || left !== p_left || right !== p_right);
            if (load) begin
                loads++;
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_frame: got %h_%h expected no frame at %0t", left, right, $time);
                end else begin
                    f = exp_q.pop_front();
                    chk("frame_left", left, f[2*DW-1:DW]);
                    chk("frame_right", right, f[DW-1:0]);
                end
            end
            if (load && p_valid && !p_ready) ovr_exp = 1'b1;
            else if (p_clear) ovr_exp = 1'b0;
            if (p_valid && !p_ready && !valid) chk("valid_hold", valid, 1);
            chk("overrun", overrun, ovr_exp);
            chk("locked", locked, state != SYNC);
            if (frame_err) begin
                ferr_cnt++;
                if (p_ferr) chk("ferr_pulse_width", 2, 1);
            end
        end
        p_valid = valid;
        p_ready = ready;
        p_clear = clear;
        p_rstn  = rst_n;
        p_left  = left;
        p_right = right;
        p_ferr  = frame_err;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #2;
            ready = ($urandom_range(0, 199) == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 ready = v;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #2 clear = 1'b1;
        @(posedge clk);
        #2 clear = 1'b0;
    endtask

    task automatic bclk_cycle(input logic lr, input logic d);
        int h;
        h = $urandom_range(25, 40);
        bclk  = 1'b0;
        lrclk = lr;
        din   = d;
        #(h);
        bclk = 1'b1;
        h = $urandom_range(25, 40);
        #(h);
    endtask

    task automatic stall_link();
        repeat (1000) @(negedge clk);
        chk("locked_before_timeout", locked, 1);
        repeat (40) @(negedge clk);
        chk("locked_after_timeout", locked, 0);
        chk("state_after_timeout", state, SYNC);
        repeat (60) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        chk("pre_reset_valid", valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_reset_valid", valid, 0);
        chk("mid_reset_left", left, 0);
        chk("mid_reset_right", right, 0);
        chk("mid_reset_state", state, SYNC);
    endtask

    // ev_kind 1 = BCLK stall, 2 = reset pulse, before bit ev_at of the slot.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int len,
                             input int ev_at, input int ev_kind);
        for (int i = 0; i < len; i++) begin
            logic b;
            if (i == ev_at && ev_kind == 1) stall_link();
            if (i == ev_at && ev_kind == 2) pulse_reset();
            b = (i < DW) ? w[DW-1-i] : 1'($urandom_range(0, 1));
            bclk_cycle(lr, bit_prev);
            bit_prev = b;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int llen,
                              input int ev_kind, input int ev_at);
        send_slot(1'b0, l, llen, (ev_kind == 2) ? ev_at : -1, ev_kind);
        send_slot(1'b1, r, SB, (ev_kind == 1) ? ev_at : -1, ev_kind);
        if (llen == SB && ev_kind == 0) exp_q.push_back({l, r});
    endtask

    task automatic preamble();
        send_slot(1'b1, 16'($urandom), SB, -1, 0);
    endtask

    task automatic end_burst();
        send_slot(1'b0, '0, 2, -1, 0);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("frames_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (1100) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int l0, f0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // DAC loopback pattern
        l0 = loads; f0 = ferr_cnt;
        preamble();
        send_frame(16'h8001, 16'h7FFE, SB, 0, -1);
        end_burst();
        chk("loop_left", left, 16'h8001);
        chk("loop_right", right, 16'h7FFE);
        chk("loop_frames", loads - l0, 1);
        chk("loop_ferr", ferr_cnt - f0, 0);

        // Continuous counter stream, always ready
        l0 = loads;
        preamble();
        for (int n = 0; n < 100; n++) send_frame(16'(n), ~16'(n), SB, 0, -1);
        end_burst();
        chk("stream_frames", loads - l0, 100);
        chk("stream_overrun", overrun, 0);
        chk("stream_last_left", left, 16'd99);

        // Consumer stalled over three frames
        set_ready(1'b0);
        preamble();
        send_frame(16'h1111, 16'h1111, SB, 0, -1);
        send_frame(16'h2222, 16'h2222, SB, 0, -1);
        send_frame(16'h3333, 16'h3333, SB, 0, -1);
        end_burst();
        @(negedge clk);
        chk("ovr_valid_held", valid, 1);
        chk("ovr_left", left, 16'h3333);
        chk("ovr_flag", overrun, 1);
        set_ready(1'b1);
        set_ready(1'b0);
        @(negedge clk);
        chk("ovr_accepted", valid, 0);
        chk("ovr_still_set", overrun, 1);
        pulse_clear();
        @(negedge clk);
        chk("ovr_cleared", overrun, 0);

        // Short left slot
        set_ready(1'b1);
        l0 = loads; f0 = ferr_cnt;
        preamble();
        send_frame(16'hAAAA, 16'h5555, SB, 0, -1);
        send_frame(16'h1234, 16'h4321, SB - 1, 0, -1);
        @(negedge clk);
        chk("ferr_unlocked", locked, 0);
        chk("ferr_count", ferr_cnt - f0, 1);
        send_frame(16'hBEEF, 16'hCAFE, SB, 0, -1);
        end_burst();
        chk("ferr_frames", loads - l0, 2);
        chk("ferr_relock_left", left, 16'hBEEF);
        chk("ferr_relock_right", right, 16'hCAFE);

        // BCLK stall inside a right slot
        l0 = loads; f0 = ferr_cnt;
        preamble();
        send_frame(16'h1357, 16'h2468, SB, 0, -1);
        send_frame(16'hDEAD, 16'hBEEF, SB, 1, 5);
        send_frame(16'h0F0F, 16'hF0F0, SB, 0, -1);
        end_burst();
        chk("timeout_ferr", ferr_cnt - f0, 0);
        chk("timeout_frames", loads - l0, 2);
        chk("timeout_left", left, 16'h0F0F);

        // Reset mid-frame while a frame is held
        set_ready(1'b0);
        preamble();
        send_frame(16'h1111, 16'hAAAA, SB, 0, -1);
        send_frame(16'h2222, 16'hBBBB, SB, 2, 8);
        send_frame(16'h3333, 16'hCCCC, SB, 0, -1);
        end_burst();
        @(negedge clk);
        chk("post_reset_left", left, 16'h3333);
        chk("post_reset_right", right, 16'hCCCC);
        chk("post_reset_overrun", overrun, 0);
        set_ready(1'b1);

        // Random data with a sluggish consumer
        rand_ready = 1'b1;
        preamble();
        for (int n = 0; n < 20; n++) send_frame(16'($urandom), 16'($urandom), SB, 0, -1);
        end_burst();
        rand_ready = 1'b0;
        set_ready(1'b1);
        pulse_clear();
        repeat (4) @(negedge clk);
        chk("final_overrun", overrun, 0);
        chk("final_valid", valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
